// File: rtl/axi_mst_write.sv
// axi_mst_write: AXI4 single-burst write master fed by an AXIS stream.
//   clk, rst            : single clock, synchronous active-high reset
//   m_axi_aw*           : write address channel (one INCR burst per START)
//   m_axi_w*            : write data channel, drained from the AXIS FIFO
//   m_axi_b*            : write response channel; BRESP is latched
//   s_axis_*            : stream input into the internal FWFT FIFO
//   START_REG/ADDR_REG/LENGTH_REG : burst control
//   WIDLE_REG/WRESP_REG           : idle flag and last burst response
module axi_mst_write #(
    parameter int unsigned ID_WIDTH   = 1,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned FIFO_DEPTH = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic [ID_WIDTH-1:0]       m_axi_awid,
    output logic [31:0]               m_axi_awaddr,
    output logic [3:0]                m_axi_awlen,
    output logic [2:0]                m_axi_awsize,
    output logic [1:0]                m_axi_awburst,
    output logic                      m_axi_awlock,
    output logic [3:0]                m_axi_awcache,
    output logic [2:0]                m_axi_awprot,
    output logic [3:0]                m_axi_awregion,
    output logic [3:0]                m_axi_awqos,
    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,
    output logic [DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb,
    output logic                      m_axi_wlast,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,
    input  logic [ID_WIDTH-1:0]       m_axi_bid,
    input  logic [1:0]                m_axi_bresp,
    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready,
    input  logic                      s_axis_tvalid,
    input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
    output logic                      s_axis_tready,
    input  logic                      START_REG,
    input  logic [31:0]               ADDR_REG,
    input  logic [31:0]               LENGTH_REG,
    output logic                      WIDLE_REG,
    output logic [1:0]                WRESP_REG
);

    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned SIZE_V = $clog2(STRB_W);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;

    typedef enum logic [2:0] {
        INIT_ST,
        START_ST,
        READ_REGS_ST,
        ADDR_ST,
        DATA_ST,
        RESP_ST,
        END_ST
    } state_e;

    state_e              state_q, state_d;
    logic [31:0]         addr_q, addr_d;
    logic [4:0]          len_q, len_d;
    logic [4:0]          beat_q, beat_d;
    logic [1:0]          wresp_q, wresp_d;

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]    count_q;
    logic                fifo_full, fifo_empty, push, pop;
    logic [4:0]          len_in;
    logic                unused_ok;

    // FIFO status; a push on a full FIFO is refused even if a pop happens
    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign push       = s_axis_tvalid & ~fifo_full;
    assign pop        = m_axi_wvalid & m_axi_wready;
    assign len_in     = LENGTH_REG[4:0];

    // AXI outputs derived from registered state
    assign m_axi_awid     = '0;
    assign m_axi_awaddr   = addr_q;
    assign m_axi_awlen    = 4'(len_q - 5'd1);
    assign m_axi_awsize   = 3'(SIZE_V);
    assign m_axi_awburst  = 2'b01;
    assign m_axi_awlock   = 1'b0;
    assign m_axi_awcache  = 4'b0000;
    assign m_axi_awprot   = 3'b010;
    assign m_axi_awregion = 4'b0000;
    assign m_axi_awqos    = 4'b0000;
    assign m_axi_awvalid  = (state_q == ADDR_ST);
    assign m_axi_wdata    = mem_q[rd_ptr_q];
    assign m_axi_wstrb    = '1;
    assign m_axi_wvalid   = (state_q == DATA_ST) & ~fifo_empty;
    assign m_axi_wlast    = m_axi_wvalid & (beat_q == (len_q - 5'd1));
    assign m_axi_bready   = (state_q == RESP_ST);
    assign s_axis_tready  = ~fifo_full;
    assign WIDLE_REG      = (state_q == START_ST);
    assign WRESP_REG      = wresp_q;

    // Inputs intentionally not used by the datapath
    assign unused_ok = ^{m_axi_bid, LENGTH_REG[31:5]};

    // Next-state logic
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        beat_d  = beat_q;
        wresp_d = wresp_q;
        case (state_q)
            INIT_ST:  state_d = START_ST;
            START_ST: if (START_REG) state_d = READ_REGS_ST;
            READ_REGS_ST: begin
                addr_d = ADDR_REG;
                len_d  = len_in;
                beat_d = '0;
                // Lengths outside 1..16 skip the bus entirely
                if ((len_in != 5'd0) && (len_in <= 5'd16)) state_d = ADDR_ST;
                else                                       state_d = END_ST;
            end
            ADDR_ST:  if (m_axi_awready) state_d = DATA_ST;
            DATA_ST: begin
                if (pop) begin
                    beat_d = beat_q + 5'd1;
                    if (m_axi_wlast) state_d = RESP_ST;
                end
            end
            RESP_ST: begin
                if (m_axi_bvalid) begin
                    wresp_d = m_axi_bresp;
                    state_d = END_ST;
                end
            end
            // Wait for START to drop so a held level cannot relaunch
            END_ST:   if (!START_REG) state_d = START_ST;
            default:  state_d = INIT_ST;
        endcase
    end

    // Control and FIFO pointer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= INIT_ST;
            addr_q   <= '0;
            len_q    <= '0;
            beat_q   <= '0;
            wresp_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            wresp_q <= wresp_d;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // FIFO storage; contents need no reset since the pointers gate visibility
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= s_axis_tdata;
    end

endmodule

// File: tb/tb_axi_mst_write.sv
module tb_axi_mst_write;

    localparam int unsigned IW    = 1;
    localparam int unsigned DW    = 64;
    localparam int unsigned DEPTH = 64;

    logic clk, rst;
    logic [IW-1:0]   awid;
    logic [31:0]     awaddr;
    logic [3:0]      awlen, awcache, awregion, awqos;
    logic [2:0]      awsize, awprot;
    logic [1:0]      awburst;
    logic            awlock, awvalid, awready;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            wlast, wvalid, wready;
    logic [IW-1:0]   bid;
    logic [1:0]      bresp;
    logic            bvalid, bready;
    logic            tvalid, tready;
    logic [DW-1:0]   tdata;
    logic            start;
    logic [31:0]     addr_reg, len_reg;
    logic            widle;
    logic [1:0]      wresp;

    axi_mst_write #(.ID_WIDTH(IW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen),
        .m_axi_awsize(awsize), .m_axi_awburst(awburst), .m_axi_awlock(awlock),
        .m_axi_awcache(awcache), .m_axi_awprot(awprot), .m_axi_awregion(awregion),
        .m_axi_awqos(awqos), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
        .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_bid(bid), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
        .s_axis_tvalid(tvalid), .s_axis_tdata(tdata), .s_axis_tready(tready),
        .START_REG(start), .ADDR_REG(addr_reg), .LENGTH_REG(len_reg),
        .WIDLE_REG(widle), .WRESP_REG(wresp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] len;
        logic [31:0] addr;
        int          preload;
        bit          stall;
        logic [1:0]  bresp;
        int          exp_aw;
        int          exp_beats;
        logic [3:0]  exp_awlen;
        logic [1:0]  exp_wresp;
        bit          consec;
        logic [63:0] exp_last;
    } vec_t;

    vec_t tbl [6];

    int errors = 0;
    int checks = 0;

    // Scoreboard / monitor state
    logic [63:0] q [$];
    int aw_cnt, awv_cnt, beats, wlast_cnt, wlast_beat, b_cnt, wgap;
    int first_cyc, last_cyc, first_awv_cyc, start_cyc;
    int cyc = 0;
    int word_ctr = 0;
    logic [63:0] last_wdata, prev_wdata, expd;
    logic [31:0] cap_awaddr, prev_awaddr;
    logic [3:0]  cap_awlen, prev_awlen;
    bit prev_aw_stall, prev_w_stall, acc, stall_mode;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_burst();
        aw_cnt = 0; awv_cnt = 0; beats = 0; wlast_cnt = 0; wlast_beat = 0;
        b_cnt = 0; wgap = 0; first_cyc = -1; last_cyc = -1; first_awv_cyc = -1;
        last_wdata = '0;
    endtask

    // Mid-cycle sampling of all DUT outputs against the FIFO model
    task automatic monitor();
        acc = 1'b0;
        if (rst) begin
            q.delete();
            prev_aw_stall = 1'b0;
            prev_w_stall  = 1'b0;
        end else begin
            chk("tready", 64'(tready), 64'(q.size() < DEPTH));
            if (prev_aw_stall) begin
                chk("aw_hold", 64'(awvalid), 64'(1));
                chk("aw_stable_addr", 64'(awaddr), 64'(prev_awaddr));
                chk("aw_stable_len", 64'(awlen), 64'(prev_awlen));
            end
            if (awvalid) begin
                awv_cnt++;
                if (first_awv_cyc < 0) first_awv_cyc = cyc;
                if (awready) begin
                    aw_cnt++;
                    cap_awaddr = awaddr;
                    cap_awlen  = awlen;
                end
            end
            prev_aw_stall = awvalid && !awready;
            prev_awaddr   = awaddr;
            prev_awlen    = awlen;
            if (prev_w_stall) begin
                chk("w_hold", 64'(wvalid), 64'(1));
                chk("w_stable_data", wdata, prev_wdata);
            end
            if (wvalid) begin
                chk("w_after_aw", 64'(aw_cnt != 0), 64'(1));
                if (wready) begin
                    chk("fifo_has_data", 64'(q.size() != 0), 64'(1));
                    expd = (q.size() != 0) ? q.pop_front() : '0;
                    chk("wdata", wdata, expd);
                    beats++;
                    if (first_cyc < 0) first_cyc = cyc;
                    last_cyc = cyc;
                    if (wlast) begin
                        wlast_cnt++;
                        wlast_beat = beats;
                        last_wdata = wdata;
                    end
                end
            end else if (aw_cnt > 0 && wlast_cnt == 0) begin
                wgap++;
            end
            prev_w_stall = wvalid && !wready;
            prev_wdata   = wdata;
            if (bvalid && bready) b_cnt++;
            if (tvalid && tready) begin
                q.push_back(tdata);
                acc = 1'b1;
            end
        end
        cyc++;
    endtask

    // One clock: sample at negedge, drive just after posedge
    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        if (acc) word_ctr++;
        tdata = 64'(word_ctr);
        if (stall_mode) begin
            awready = 1'($urandom_range(0, 1));
            wready  = 1'($urandom_range(0, 1));
            bvalid  = 1'($urandom_range(0, 1));
        end else begin
            awready = 1'b1;
            wready  = 1'b1;
            bvalid  = 1'b1;
        end
    endtask

    task automatic push_words(input int n);
        int got = 0;
        int guard = 0;
        tvalid = 1'b1;
        while (got < n && guard < 1000) begin
            step();
            if (acc) got++;
            guard++;
        end
        tvalid = 1'b0;
        chk("preload_count", 64'(got), 64'(n));
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        while (!widle && n < max) begin
            step();
            n++;
        end
        chk("idle_reached", 64'(widle), 64'(1));
    endtask

    task automatic pulse_start();
        clear_burst();
        start_cyc = cyc;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic run_burst(input vec_t v);
        stall_mode = v.stall;
        bresp      = v.bresp;
        len_reg    = v.len;
        addr_reg   = v.addr;
        if (v.preload > 0) push_words(v.preload);
        pulse_start();
        wait_idle(600);
        stall_mode = 1'b0;
        chk("aw_count", 64'(aw_cnt), 64'(v.exp_aw));
        chk("b_count", 64'(b_cnt), 64'(v.exp_aw));
        chk("beats", 64'(beats), 64'(v.exp_beats));
        chk("wlast_count", 64'(wlast_cnt), 64'(v.exp_beats > 0));
        chk("wresp", 64'(wresp), 64'(v.exp_wresp));
        if (v.exp_aw == 0) begin
            chk("no_awvalid", 64'(awv_cnt), 64'(0));
        end else begin
            chk("awaddr", 64'(cap_awaddr), 64'(v.addr));
            chk("awlen", 64'(cap_awlen), 64'(v.exp_awlen));
            chk("aw_latency", 64'(first_awv_cyc - start_cyc), 64'(2));
            chk("wlast_beat", 64'(wlast_beat), 64'(v.exp_beats));
            chk("last_wdata", last_wdata, v.exp_last);
        end
        if (v.consec) chk("consecutive", 64'(last_cyc - first_cyc), 64'(v.exp_beats - 1));
    endtask

    initial begin
        int fed, got, n;
        vec_t v;

        tbl[0] = '{32'd16,    32'h1000, 16, 1'b0, 2'b00, 1, 16, 4'd15, 2'b00, 1'b1, 64'd15};
        tbl[1] = '{32'd8,     32'h2040,  8, 1'b1, 2'b10, 1,  8, 4'd7,  2'b10, 1'b0, 64'd23};
        tbl[2] = '{32'd0,     32'h3000,  0, 1'b0, 2'b01, 0,  0, 4'd0,  2'b10, 1'b0, 64'd0};
        tbl[3] = '{32'd17,    32'h3000,  0, 1'b0, 2'b01, 0,  0, 4'd0,  2'b10, 1'b0, 64'd0};
        tbl[4] = '{32'd1,     32'h0008,  1, 1'b0, 2'b01, 1,  1, 4'd0,  2'b01, 1'b1, 64'd24};
        tbl[5] = '{32'h25,    32'h4000,  5, 1'b0, 2'b00, 1,  5, 4'd4,  2'b00, 1'b1, 64'd29};

        rst = 1'b1; start = 1'b0; addr_reg = '0; len_reg = '0;
        tvalid = 1'b0; tdata = '0; bid = '0; bresp = 2'b00;
        awready = 1'b1; wready = 1'b1; bvalid = 1'b1; stall_mode = 1'b0;
        prev_aw_stall = 1'b0; prev_w_stall = 1'b0;
        clear_burst();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_awvalid", 64'(awvalid), 64'(0));
        chk("rst_wvalid", 64'(wvalid), 64'(0));
        chk("rst_bready", 64'(bready), 64'(0));
        chk("rst_widle", 64'(widle), 64'(0));
        chk("rst_wresp", 64'(wresp), 64'(0));
        chk("awsize", 64'(awsize), 64'(3));
        chk("awburst", 64'(awburst), 64'(1));
        chk("awprot", 64'(awprot), 64'(2));
        chk("awid", 64'(awid), 64'(0));
        chk("wstrb", 64'(wstrb), 64'hFF);
        rst = 1'b0;
        step();
        chk("init_to_start", 64'(widle), 64'(1));

        for (int i = 0; i < 6; i++) run_burst(tbl[i]);

        // START held high after an invalid length: stays in END, no relaunch
        bresp = 2'b11;
        len_reg = 32'd0;
        clear_burst();
        start = 1'b1;
        repeat (6) step();
        chk("held_start_widle", 64'(widle), 64'(0));
        chk("held_start_noaw", 64'(awv_cnt), 64'(0));
        start = 1'b0;
        wait_idle(20);
        chk("held_start_wresp", 64'(wresp), 64'(0));

        // Empty FIFO at start, one word every third cycle
        bresp = 2'b00;
        len_reg = 32'd4;
        addr_reg = 32'h5000;
        pulse_start();
        fed = 0;
        n = 0;
        while (!widle && n < 300) begin
            tvalid = ((n % 3) == 0) && (fed < 4);
            step();
            if (acc) fed++;
            n++;
        end
        tvalid = 1'b0;
        chk("trickle_idle", 64'(widle), 64'(1));
        chk("trickle_beats", 64'(beats), 64'(4));
        chk("trickle_wlast_beat", 64'(wlast_beat), 64'(4));
        chk("trickle_wlast_cnt", 64'(wlast_cnt), 64'(1));
        chk("trickle_gaps", 64'(wgap > 0), 64'(1));
        chk("trickle_last", last_wdata, 64'd33);

        // Offer 80 words with no burst: FIFO fills at 64
        tvalid = 1'b1;
        got = 0;
        repeat (80) begin
            step();
            if (acc) got++;
        end
        chk("fill_accepted", 64'(got), 64'(64));
        chk("fill_tready_low", 64'(tready), 64'(0));
        bresp = 2'b11;
        len_reg = 32'd16;
        addr_reg = 32'h6000;
        pulse_start();
        got = acc ? 1 : 0;
        n = 0;
        while (!widle && n < 300) begin
            step();
            if (acc) got++;
            n++;
        end
        tvalid = 1'b0;
        chk("full_burst_beats", 64'(beats), 64'(16));
        chk("full_burst_last", last_wdata, 64'd49);
        chk("full_refill", 64'(got), 64'(16));
        chk("full_wresp", 64'(wresp), 64'(3));

        // Reset during beat 5 of a 16-beat burst
        bresp = 2'b00;
        len_reg = 32'd16;
        addr_reg = 32'h7000;
        pulse_start();
        n = 0;
        while (beats < 5 && n < 100) begin
            step();
            n++;
        end
        chk("reached_beat5", 64'(beats), 64'(5));
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_awvalid", 64'(awvalid), 64'(0));
        chk("midrst_wvalid", 64'(wvalid), 64'(0));
        chk("midrst_bready", 64'(bready), 64'(0));
        chk("midrst_widle", 64'(widle), 64'(0));
        chk("midrst_wresp", 64'(wresp), 64'(0));
        chk("midrst_tready", 64'(tready), 64'(1));
        q.delete();
        prev_aw_stall = 1'b0;
        prev_w_stall  = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_start_st", 64'(widle), 64'(1));
        chk("midrst_no_w", 64'(wvalid), 64'(0));
        v = '{32'd1, 32'h8000, 1, 1'b0, 2'b01, 1, 1, 4'd0, 2'b01, 1'b1, 64'd114};
        run_burst(v);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
